// File: rtl/axis_sum_exerciser_if.sv
// AXI-Stream bundle shared by the exerciser's stimulus and result ports.
// The master modport drives a stream; the slave modport accepts one.
interface axis_sum_exerciser_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  TVALID;
  logic [DATA_WIDTH-1:0] TDATA;
  logic                  TLAST;
  logic                  TREADY;

  modport master (
    output TVALID,
    output TDATA,
    output TLAST,
    input  TREADY
  );

  modport slave (
    input  TVALID,
    input  TDATA,
    input  TLAST,
    output TREADY
  );

endinterface

// File: rtl/axis_sum_exerciser.sv
// Traffic master and result checker for the stream summing accelerator.
// Sends num_pkts packets of an incrementing word pattern, accumulates the
// expected sum locally, then checks every returned result beat against it.
module axis_sum_exerciser #(
  parameter int DATA_WIDTH   = 32,
  parameter int PKT_WORDS    = 8,
  parameter int RESULT_WORDS = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [15:0]           num_pkts,
  axis_sum_exerciser_if.master  m_axis,
  axis_sum_exerciser_if.slave   s_axis,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           pkt_count,
  output logic [15:0]           err_count
);

  // Index widths stay at least one bit so single-word packets still elaborate.
  localparam int TX_W = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam int RX_W = (RESULT_WORDS > 1) ? $clog2(RESULT_WORDS) : 1;
  localparam logic [TX_W-1:0] TX_LAST = TX_W'(PKT_WORDS - 1);
  localparam logic [RX_W-1:0] RX_LAST = RX_W'(RESULT_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [TX_W-1:0]       tx_idx_q, tx_idx_d;
  logic [RX_W-1:0]       rx_idx_q, rx_idx_d;
  logic [15:0]           num_pkts_q, num_pkts_d;
  logic [15:0]           pkt_count_q, pkt_count_d;
  logic [15:0]           err_count_q, err_count_d;

  logic tx_hs;
  logic rx_hs;
  logic tx_is_last;
  logic rx_is_last;
  logic beat_bad;

  // Handshake and beat-quality decode; valid/ready on our side come
  // straight from the registered state, so these are glitch-free qualifiers.
  always_comb begin
    tx_hs      = (state_q == SEND) && m_axis.TREADY;
    rx_hs      = (state_q == RECV) && s_axis.TVALID;
    tx_is_last = (tx_idx_q == TX_LAST);
    rx_is_last = (rx_idx_q == RX_LAST);
    beat_bad   = (s_axis.TDATA != sum_q) || (s_axis.TLAST != rx_is_last);
  end

  // Next-state and datapath updates for the send/check sequencer.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    sum_d       = sum_q;
    tx_idx_d    = tx_idx_q;
    rx_idx_d    = rx_idx_q;
    num_pkts_d  = num_pkts_q;
    pkt_count_d = pkt_count_q;
    err_count_d = err_count_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          num_pkts_d  = num_pkts;
          word_d      = seed;
          sum_d       = '0;
          tx_idx_d    = '0;
          rx_idx_d    = '0;
          pkt_count_d = '0;
          err_count_d = '0;
          state_d     = (num_pkts == 16'd0) ? DONE : SEND;
        end
      end

      SEND: begin
        if (tx_hs) begin
          sum_d  = sum_q + word_q;
          word_d = word_q + DATA_WIDTH'(1);
          if (tx_is_last) begin
            tx_idx_d = '0;
            rx_idx_d = '0;
            state_d  = RECV;
          end else begin
            tx_idx_d = tx_idx_q + TX_W'(1);
          end
        end
      end

      RECV: begin
        if (rx_hs) begin
          if (beat_bad && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
          end
          if (rx_is_last) begin
            rx_idx_d    = '0;
            sum_d       = '0;
            pkt_count_d = pkt_count_q + 16'd1;
            state_d     = ((pkt_count_q + 16'd1) == num_pkts_q) ? DONE : SEND;
          end else begin
            rx_idx_d = rx_idx_q + RX_W'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any packet in flight.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      word_q      <= '0;
      sum_q       <= '0;
      tx_idx_q    <= '0;
      rx_idx_q    <= '0;
      num_pkts_q  <= '0;
      pkt_count_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      sum_q       <= sum_d;
      tx_idx_q    <= tx_idx_d;
      rx_idx_q    <= rx_idx_d;
      num_pkts_q  <= num_pkts_d;
      pkt_count_q <= pkt_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign m_axis.TVALID = (state_q == SEND);
  assign m_axis.TDATA  = word_q;
  assign m_axis.TLAST  = (state_q == SEND) && tx_is_last;
  assign s_axis.TREADY = (state_q == RECV);

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign pkt_count = pkt_count_q;
  assign err_count = err_count_q;

endmodule

// File: doc/axis_sum_exerciser.md
# axis_sum_exerciser

AXI-Stream traffic master and response checker for the stream summing accelerator. Drives fixed-length packets of an incrementing data pattern into the accelerator's slave stream port. Receives the accelerator's result stream on its own slave port and checks every result word against a locally accumulated sum. Reports pass/fail counts to software or a testbench, and sits in the PL loopback path in place of the DMA engine.

## Interface
- DATA_WIDTH, 32, stream data width; all arithmetic is modulo 2^DATA_WIDTH
- PKT_WORDS, 8, words sent per packet (≥1)
- RESULT_WORDS, 8, result words expected back per packet (≥1)
- ACLK  in  1  clock, all logic on rising edge
- ARESETN  in  1  reset, asynchronous, active-low
- start  in  1  run request, sampled only in IDLE
- seed  in  DATA_WIDTH  first data word of the run, latched on start
- num_pkts  in  16  packets in the run, latched on start
- M_AXIS_TVALID  out  1  stimulus word valid
- M_AXIS_TDATA  out  DATA_WIDTH  stimulus word
- M_AXIS_TLAST  out  1  last word of stimulus packet
- M_AXIS_TREADY  in  1  accelerator accepts word
- S_AXIS_TVALID  in  1  result word valid
- S_AXIS_TDATA  in  DATA_WIDTH  result word
- S_AXIS_TLAST  in  1  result packet end marker
- S_AXIS_TREADY  out  1  checker accepts result word
- busy  out  1  run in progress (state ≠ IDLE)
- done  out  1  one-cycle pulse at end of run
- pkt_count  out  16  packets fully checked in current/last run
- err_count  out  16  mismatching result beats, saturates at 0xFFFF

## Operation
- The block has four states: IDLE, SEND, RECV and DONE. Outputs are decoded from the registered state and counters:
  - M_AXIS_TVALID = (state == SEND)
  - S_AXIS_TREADY = (state == RECV)
  - busy = (state != IDLE)
  - done = (state == DONE)
- **IDLE:**
  - On start=1, latch num_pkts.
  - Load word register ← seed, sum ← 0, pkt_count ← 0, err_count ← 0.
  - Go to SEND, or go to DONE if num_pkts == 0.
- **SEND:**
  - M_AXIS_TDATA = word register.
  - M_AXIS_TLAST = 1 when tx index == PKT_WORDS-1.
  - On each handshake (TVALID&TREADY): sum ← sum + word, word ← word + 1, tx index++.
  - On the handshake of the last word, go to RECV with rx index ← 0. The sum register then holds the expected result.
- **RECV:**
  - On each handshake (TVALID&TREADY) the beat is wrong if S_AXIS_TDATA ≠ sum, or S_AXIS_TLAST ≠ (rx index == RESULT_WORDS-1).
  - A wrong beat increments err_count once (saturating).
  - Exactly RESULT_WORDS beats are consumed, whatever TLAST says.
  - After the last beat: pkt_count++ and sum ← 0.
  - If pkt_count+1 == latched num_pkts, go to DONE; otherwise go to SEND.
- **Word register across packets:** it carries over between packets, so packet p starts at seed + p·PKT_WORDS (mod 2^DATA_WIDTH).
- **DONE:** lasts one cycle, then IDLE. pkt_count and err_count hold until the next accepted start.
- **start outside IDLE:** ignored.
- **Input changes mid-run:** changes to seed and num_pkts while busy have no effect.

## Timing
- **Reset values (asserted asynchronously):** state = IDLE; all outputs 0 (M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, S_AXIS_TREADY, busy, done, pkt_count, err_count).
- **Reset mid-run:** abandons the packet immediately. No further beats are driven, and counters clear.
- **Run start:** start is sampled at edge N. The first stimulus word is valid in cycle N+1.
- **Stimulus stability:** while M_AXIS_TVALID=1 and TREADY=0, TDATA and TLAST hold stable. TVALID is never withdrawn before its handshake.
- **SEND to RECV:** the last stimulus handshake at edge K gives S_AXIS_TREADY=1 in cycle K+1.
- **RECV to SEND:** the last result handshake at edge R gives the next packet's first word valid in cycle R+1, or done=1 in cycle R+1.
- **Zero packets:** with num_pkts=0, done=1 in cycle N+1 and no beats occur.
- **Throughput:** one beat per cycle in each direction under full ready/valid.
- **Ignored inputs:** result beats arriving outside RECV are not accepted (TREADY=0). The accelerator must hold them per AXI-Stream rules.

## Test plan
- **Basic run.** seed=1, num_pkts=2, ideal loopback accelerator.
  - Stimulus: 1..8 with TLAST on 8, then 9..16.
  - Expected results: 8×36, then 8×100.
  - Required: pkt_count=2, err_count=0, single done pulse.
- **Wrap-around.** seed=0xFFFFFFFC, num_pkts=1.
  - Stimulus: 0xFFFFFFFC..0x00000003.
  - Expected sum: 0xFFFFFFFC.
  - Required: err_count=0.
- **Backpressure.** Random M_AXIS_TREADY and S_AXIS_TVALID with 50% duty.
  - Required: M_AXIS_TDATA/TLAST stable while stalled.
  - Required: the same word sequence and counts as the basic run.
- **Error injection.** Corrupt result word 3 of packet 0 to 0, and drop TLAST on word 7 of packet 1.
  - Required: err_count=2, pkt_count=2.
- **Zero packets and ignored start.** num_pkts=0 gives done at N+1 with no beats.
  - A start pulse during SEND is ignored: the run length is unchanged.
- **Reset mid-SEND.** Assert ARESETN=0 after word 4.
  - Required: all outputs 0 immediately.
  - A new start with seed=1 restarts at word 1.
